// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter slice.
//            State encoding, requester count and timeout counter width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  // Number of requesters sharing the transmitter
  localparam int NUM_REQ = 2;

  // Width of the lock-timeout counter
  localparam int TMO_W = 16;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

endpackage : uart_arb_pkg

`default_nettype wire

// File: rtl/arb_timeout_counter.sv
// ============================================================================
// Module   : arb_timeout_counter
// Purpose  : Counts idle cycles of the lock owner and flags expiry.
//            expire is combinational: high in the cycle where the count has
//            reached limit-1 and another idle cycle is being counted.
// Ports    : clk       in  clock
//            pb_reset  in  asynchronous active-high reset
//            clear     in  synchronous clear (wins over count_en)
//            count_en  in  count this cycle
//            limit     in  [W-1:0] number of idle cycles allowed
//            expire    out one-cycle expiry flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_timeout_counter
  import uart_arb_pkg::*;
#(
  parameter int W = TMO_W
) (
  input  logic         clk,
  input  logic         pb_reset,
  input  logic         clear,
  input  logic         count_en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;
  logic [W-1:0] last_count;

  assign last_count = limit - ONE;
  assign expire     = count_en && (count == last_count);

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + ONE;
    end
  end

endmodule : arb_timeout_counter

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-atomic arbiter sharing one rs232_uart
//            transmit path between two byte-stream requesters. A granted
//            requester keeps the transmitter until it delivers a byte
//            flagged last, so multi-byte messages never interleave.
// Macro    : UART_ARB_TIMEOUT_EN - when defined, a lock whose owner stays
//            idle for TIMEOUT_CYCLES cycles is revoked and timeout_pulse
//            fires; when undefined the lock is held indefinitely.
// Ports    : clk            in   system clock
//            pb_reset       in   asynchronous active-high reset
//            req0_*/req1_*  data[8], valid, last in; ready out
//            tx_data        out  [8] byte to UART (00 when no transfer)
//            write_tx_data  out  UART write enable
//            tx_buffer_full in   UART TX FIFO full
//            grant          out  [2] one-hot owner, 00 when idle (registered)
//            timeout_pulse  out  one-cycle lock-revoke pulse (registered)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic               clk,
  input  logic               pb_reset,
  input  logic [7:0]         req0_data,
  input  logic               req0_valid,
  input  logic               req0_last,
  output logic               req0_ready,
  input  logic [7:0]         req1_data,
  input  logic               req1_valid,
  input  logic               req1_last,
  output logic               req1_ready,
  output logic [7:0]         tx_data,
  output logic               write_tx_data,
  input  logic               tx_buffer_full,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout_pulse
);

  arb_state_t state;
  logic       pri;          // requester preferred on a tie
  logic       xfer0;
  logic       xfer1;
  logic       xfer_last;
  logic       expire;
  logic       release_lock;
  logic       other_valid;

  // Ready and write are combinational from the registered state so a
  // requester can stream one byte per cycle. With pb_reset high the state
  // is forced to IDLE asynchronously, which suppresses any write.
  assign req0_ready    = (state == ST_GRANT0) && !tx_buffer_full;
  assign req1_ready    = (state == ST_GRANT1) && !tx_buffer_full;
  assign xfer0         = req0_valid && req0_ready;
  assign xfer1         = req1_valid && req1_ready;
  assign write_tx_data = xfer0 || xfer1;
  assign tx_data       = xfer0 ? req0_data :
                         xfer1 ? req1_data : 8'h00;

  assign xfer_last    = (xfer0 && req0_last) || (xfer1 && req1_last);
  assign release_lock = xfer_last || expire;
  assign other_valid  = (state == ST_GRANT0) ? req1_valid : req0_valid;

`ifdef UART_ARB_TIMEOUT_EN
  logic tmo_count_en;
  logic tmo_clear;
  logic timeout_q;

  // Only cycles where the owner has nothing to send count; a stall on a
  // full FIFO with valid high is not idleness.
  assign tmo_count_en = ((state == ST_GRANT0) && !req0_valid) ||
                        ((state == ST_GRANT1) && !req1_valid);
  // Every state change out of a grant goes through a transfer or an
  // expiry, and every change into a grant leaves IDLE, so these three
  // terms cover all state changes.
  assign tmo_clear    = (state == ST_IDLE) || write_tx_data || expire;

  arb_timeout_counter #(
    .W (TMO_W)
  ) u_timeout (
    .clk      (clk),
    .pb_reset (pb_reset),
    .clear    (tmo_clear),
    .count_en (tmo_count_en),
    .limit    (TIMEOUT_CYCLES),
    .expire   (expire)
  );

  assign timeout_pulse = timeout_q;
`else
  // No revocation: the owner keeps the lock until it sends a last byte.
  // The limit term folds to zero and only keeps the parameter referenced.
  assign expire        = 1'b0 && (TIMEOUT_CYCLES != '0);
  assign timeout_pulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      state <= ST_IDLE;
      grant <= 2'b00;
      pri   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= expire;
`endif
      case (state)
        ST_IDLE: begin
          if (req0_valid && (!req1_valid || !pri)) begin
            state <= ST_GRANT0;
            grant <= 2'b01;
          end else if (req1_valid) begin
            state <= ST_GRANT1;
            grant <= 2'b10;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (release_lock) begin
            // Hand priority to the other requester; if it is already
            // waiting, grant it with no idle bubble.
            pri <= (state == ST_GRANT0);
            if (other_valid) begin
              state <= (state == ST_GRANT0) ? ST_GRANT1 : ST_GRANT0;
              grant <= (state == ST_GRANT0) ? 2'b10 : 2'b01;
            end else begin
              state <= ST_IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule : uart_tx_arbiter

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Table of per-cycle
//            input/expected-output records plus hand sequences for reset,
//            lock timeout (UART_ARB_TIMEOUT_EN) and mid-message reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       pb_reset;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       write_tx_data;
  logic       tx_buffer_full;
  logic [1:0] grant;
  logic       timeout_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .TIMEOUT_CYCLES (16'd8)
  ) dut (
    .clk            (clk),
    .pb_reset       (pb_reset),
    .req0_data      (req0_data),
    .req0_valid     (req0_valid),
    .req0_last      (req0_last),
    .req0_ready     (req0_ready),
    .req1_data      (req1_data),
    .req1_valid     (req1_valid),
    .req1_last      (req1_last),
    .req1_ready     (req1_ready),
    .tx_data        (tx_data),
    .write_tx_data  (write_tx_data),
    .tx_buffer_full (tx_buffer_full),
    .grant          (grant),
    .timeout_pulse  (timeout_pulse)
  );

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       full;
    logic [1:0] e_grant;
    logic       e_r0;
    logic       e_r1;
    logic       e_wr;
    logic [7:0] e_txd;
  } vec_t;

  vec_t vecs[21];

  // {grant, ready0, ready1, write, tx_data, timeout_pulse}
  function automatic logic [13:0] outs();
    return {grant, req0_ready, req1_ready, write_tx_data, tx_data, timeout_pulse};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1,
                       input logic full);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    tx_buffer_full = full;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pb_reset = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    pb_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Per-cycle records starting from IDLE with pri = 0
    //            v0  d0    l0 v1  d1    l1 full grant r0 r1 wr txd
    vecs[0]  = '{1, 8'h41, 0, 1, 8'hA0, 0, 0, 2'b00, 0, 0, 0, 8'h00}; // tie, arbitration cycle
    vecs[1]  = '{1, 8'h41, 0, 1, 8'hA0, 0, 0, 2'b01, 1, 0, 1, 8'h41}; // req0 wins
    vecs[2]  = '{1, 8'h42, 0, 1, 8'hA0, 0, 0, 2'b01, 1, 0, 1, 8'h42};
    vecs[3]  = '{1, 8'h43, 1, 1, 8'hA0, 0, 0, 2'b01, 1, 0, 1, 8'h43}; // last
    vecs[4]  = '{1, 8'h44, 0, 1, 8'hA0, 0, 0, 2'b10, 0, 1, 1, 8'hA0}; // no bubble
    vecs[5]  = '{1, 8'h44, 0, 1, 8'hA1, 0, 0, 2'b10, 0, 1, 1, 8'hA1};
    vecs[6]  = '{1, 8'h44, 0, 1, 8'hA2, 0, 1, 2'b10, 0, 0, 0, 8'h00}; // full x5
    vecs[7]  = '{1, 8'h44, 0, 1, 8'hA2, 0, 1, 2'b10, 0, 0, 0, 8'h00};
    vecs[8]  = '{1, 8'h44, 0, 1, 8'hA2, 0, 1, 2'b10, 0, 0, 0, 8'h00};
    vecs[9]  = '{1, 8'h44, 0, 1, 8'hA2, 0, 1, 2'b10, 0, 0, 0, 8'h00};
    vecs[10] = '{1, 8'h44, 0, 1, 8'hA2, 0, 1, 2'b10, 0, 0, 0, 8'h00};
    vecs[11] = '{1, 8'h44, 0, 1, 8'hA2, 0, 0, 2'b10, 0, 1, 1, 8'hA2}; // resumes
    vecs[12] = '{1, 8'h44, 0, 1, 8'hA3, 1, 0, 2'b10, 0, 1, 1, 8'hA3}; // req1 last
    vecs[13] = '{1, 8'h44, 1, 0, 8'h00, 0, 0, 2'b01, 1, 0, 1, 8'h44}; // back to req0
    vecs[14] = '{1, 8'h45, 1, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 8'h00}; // re-request: IDLE
    vecs[15] = '{1, 8'h45, 1, 0, 8'h00, 0, 0, 2'b01, 1, 0, 1, 8'h45}; // re-granted
    vecs[16] = '{1, 8'h50, 1, 1, 8'hB0, 1, 0, 2'b00, 0, 0, 0, 8'h00}; // tie, pri = 1
    vecs[17] = '{1, 8'h50, 1, 1, 8'hB0, 1, 0, 2'b10, 0, 1, 1, 8'hB0}; // req1 wins
    vecs[18] = '{1, 8'h50, 1, 1, 8'hB0, 1, 0, 2'b01, 1, 0, 1, 8'h50};
    vecs[19] = '{0, 8'h00, 0, 1, 8'hB1, 1, 0, 2'b10, 0, 1, 1, 8'hB1};
    vecs[20] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 0, 0, 0, 8'h00};

    pb_reset = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);

    // ---- Reset with random inputs: every output held at zero ----
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 1'b0);
      #1 check("reset_outputs", 32'(outs()), 32'h0);
    end
    @(negedge clk);
    pb_reset = 1'b0;
    drive(1, 8'h33, 1, 0, 8'h00, 0, 0);
    #1 check("post_reset_idle", 32'(outs()), 32'h0);
    @(negedge clk);
    #1 check("first_grant", 32'(outs()), {18'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0});
    req0_valid = 1'b0;

    // ---- Table: contention, atomicity, backpressure, round-robin ----
    do_reset();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1,
            vecs[i].l1, vecs[i].full);
      #1 check($sformatf("vec%0d", i), 32'(outs()),
               {18'h0, vecs[i].e_grant, vecs[i].e_r0, vecs[i].e_r1,
                vecs[i].e_wr, vecs[i].e_txd, 1'b0});
    end

    // ---- Lock timeout: req0 goes idle mid-message while req1 waits ----
    do_reset();
    @(negedge clk);
    drive(1, 8'h60, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    #1 check("tmo_first_byte", 32'(outs()), {18'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h60, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive(0, 8'h00, 0, 1, 8'h61, 1, 0);
      #1 check($sformatf("tmo_hold%0d", k), 32'(outs()),
               {18'h0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    end
`ifdef UART_ARB_TIMEOUT_EN
    @(negedge clk);
    #1 check("tmo_revoke", 32'(outs()), {18'h0, 2'b10, 1'b0, 1'b1, 1'b1, 8'h61, 1'b1});
    @(negedge clk);
    req1_valid = 1'b0;
    #1 check("tmo_pulse_once", 32'(outs()), 32'h0);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1 check("tmo_disabled_hold", 32'(outs()),
               {18'h0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    req1_valid = 1'b0;
`endif

    // ---- Reset asserted in a write cycle, then fresh arbitration ----
    do_reset();
    @(negedge clk);
    drive(1, 8'h71, 1, 0, 8'h00, 0, 0);
    @(negedge clk);
    #1 check("mr_msg1", 32'(outs()), {18'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h71, 1'b0});
    @(negedge clk);
    drive(1, 8'h72, 0, 0, 8'h00, 0, 0);
    #1 check("mr_idle", 32'(outs()), 32'h0);
    @(negedge clk);
    #1 check("mr_write", 32'(outs()), {18'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h72, 1'b0});
    #2 pb_reset = 1'b1;
    #1 check("mr_reset_async", 32'(outs()), 32'h0);
    @(negedge clk);
    drive(1, 8'h72, 0, 1, 8'h73, 0, 0);
    #1 check("mr_reset_held", 32'(outs()), 32'h0);
    @(negedge clk);
    pb_reset = 1'b0;
    #1 check("mr_release_idle", 32'(outs()), 32'h0);
    @(negedge clk);
    #1 check("mr_pri_reset", 32'(outs()), {18'h0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h72, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

`default_nettype wire
